// File: rtl/icache_pkg.sv
// Shared types and address-field helpers for the direct-mapped instruction cache.
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    FILLED = 2'd2
  } cacheStateT;

  localparam int DefIndexBits = 4;
  localparam int DefWordBits  = 2;
  localparam int DefAddrW     = 32;

  function automatic int tagWidth(input int addrW, input int indexBits, input int wordBits);
    return addrW - indexBits - wordBits - 2;
  endfunction

  localparam int DefTagW = tagWidth(DefAddrW, DefIndexBits, DefWordBits);

endpackage

// File: rtl/icache_refill_fsm.sv
// Miss handling: latches the missing line, walks the beats of the refill and
// produces the memory request plus array write strobes.
module icache_refill_fsm
  import icache_pkg::*;
#(
  parameter int INDEX_BITS = DefIndexBits,
  parameter int WORD_BITS  = DefWordBits,
  parameter int ADDR_W     = DefAddrW,
  parameter int LINE_W     = ADDR_W - WORD_BITS - 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 startMiss,
  input  logic [LINE_W-1:0]    missLineIn,
  input  logic                 memRvalid,
  output cacheStateT           state,
  output logic [WORD_BITS-1:0] beat,
  output logic [LINE_W-1:0]    missLine,
  output logic                 memReq,
  output logic [ADDR_W-1:0]    memAddr,
  output logic                 dataWe,
  output logic                 lineDone
);

  cacheStateT           stateNx;
  logic [WORD_BITS-1:0] beatNx;
  logic [LINE_W-1:0]    missLineNx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      beat     <= '0;
      missLine <= '0;
    end else begin
      state    <= stateNx;
      beat     <= beatNx;
      missLine <= missLineNx;
    end
  end

  always_comb begin
    stateNx    = state;
    beatNx     = beat;
    missLineNx = missLine;
    memReq     = 1'b0;
    memAddr    = '0;
    dataWe     = 1'b0;
    lineDone   = 1'b0;
    case (state)
      IDLE: begin
        if (startMiss) begin
          missLineNx = missLineIn;
          beatNx     = '0;
          stateNx    = REFILL;
        end
      end
      REFILL: begin
        // request stays on the same beat address until the memory answers
        memReq  = 1'b1;
        memAddr = {missLine, beat, 2'b00};
        if (memRvalid) begin
          dataWe = 1'b1;
          beatNx = beat + WORD_BITS'(1);
          if (beat == '1) begin
            lineDone = 1'b1;
            stateNx  = FILLED;
          end
        end
      end
      FILLED:  stateNx = IDLE;
      default: stateNx = IDLE;
    endcase
  end

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache: register arrays, combinational
// lookup, hit/miss counters; line refill is delegated to icache_refill_fsm.
module icache_dm
  import icache_pkg::*;
#(
  parameter int INDEX_BITS = DefIndexBits,
  parameter int WORD_BITS  = DefWordBits,
  parameter int ADDR_W     = DefAddrW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pcF,
  input  logic              fetch_en,
  input  logic              inv_all,
  output logic [31:0]       instrF,
  output logic              hitF,
  output logic              stall_cache,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_rvalid,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
);

  localparam int TAG_W  = tagWidth(ADDR_W, INDEX_BITS, WORD_BITS);
  localparam int LINES  = 1 << INDEX_BITS;
  localparam int WORDS  = 1 << WORD_BITS;
  localparam int LINE_W = TAG_W + INDEX_BITS;

  logic [TAG_W-1:0]      tagF;
  logic [INDEX_BITS-1:0] idxF;
  logic [WORD_BITS-1:0]  wordF;
  logic                  unusedOffset;

  assign tagF         = pcF[ADDR_W-1 -: TAG_W];
  assign idxF         = pcF[INDEX_BITS+WORD_BITS+1 -: INDEX_BITS];
  assign wordF        = pcF[WORD_BITS+1 -: WORD_BITS];
  assign unusedOffset = ^pcF[1:0];

  logic [31:0]      dataArr [LINES][WORDS];
  logic [TAG_W-1:0] tagArr  [LINES];
  logic [LINES-1:0] validArr;

  cacheStateT            state;
  logic [WORD_BITS-1:0]  beat;
  logic [LINE_W-1:0]     missLine;
  logic                  dataWe, lineDone, missNow;
  logic [INDEX_BITS-1:0] fillIdx;
  logic [TAG_W-1:0]      fillTag;

  // hits are only reported in IDLE so a line under refill is never served
  assign hitF        = (state == IDLE) && validArr[idxF] && (tagArr[idxF] == tagF);
  assign instrF      = dataArr[idxF][wordF];
  assign missNow     = (state == IDLE) && fetch_en && !hitF;
  assign stall_cache = missNow || (state != IDLE);
  assign fillIdx     = missLine[INDEX_BITS-1:0];
  assign fillTag     = missLine[LINE_W-1 -: TAG_W];

  icache_refill_fsm #(
    .INDEX_BITS(INDEX_BITS),
    .WORD_BITS (WORD_BITS),
    .ADDR_W    (ADDR_W),
    .LINE_W    (LINE_W)
  ) uRefill (
    .clk       (clk),
    .rst       (rst),
    .startMiss (missNow),
    .missLineIn({tagF, idxF}),
    .memRvalid (mem_rvalid),
    .state     (state),
    .beat      (beat),
    .missLine  (missLine),
    .memReq    (mem_req),
    .memAddr   (mem_addr),
    .dataWe    (dataWe),
    .lineDone  (lineDone)
  );

  always_ff @(posedge clk) begin
    if (dataWe)   dataArr[fillIdx][beat] <= mem_rdata;
    if (lineDone) tagArr[fillIdx] <= fillTag;
  end

  // invalidate-all first, so a line completing in the same cycle survives
  always_ff @(posedge clk) begin
    if (rst) begin
      validArr <= '0;
    end else begin
      if (inv_all)  validArr <= '0;
      if (lineDone) validArr[fillIdx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (fetch_en && hitF) hit_cnt <= hit_cnt + 32'd1;
      if (missNow)          miss_cnt <= miss_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm with a behavioural instruction memory that can
// answer every cycle or only every third cycle of a request.
module tb_icache_dm;

  logic        clk = 1'b0;
  logic        rst, fetch_en, inv_all;
  logic [31:0] pcF, instrF, mem_addr, mem_rdata, hit_cnt, miss_cnt;
  logic        hitF, stall_cache, mem_req, mem_rvalid;

  logic        slowMode;
  logic [1:0]  waitCnt;
  int          nChk = 0, nPass = 0;
  logic [31:0] beatAddr [4];
  int          nBeats, holdErr, cyc;

  always #5 clk = ~clk;

  icache_dm dut (
    .clk        (clk),
    .rst        (rst),
    .pcF        (pcF),
    .fetch_en   (fetch_en),
    .inv_all    (inv_all),
    .instrF     (instrF),
    .hitF       (hitF),
    .stall_cache(stall_cache),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid),
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt)
  );

  // memory contents are a fixed pattern of the word address
  assign mem_rdata  = 32'hC0DE_0000 | mem_addr;
  assign mem_rvalid = mem_req && (!slowMode || waitCnt == 2'd2);

  always @(posedge clk) begin
    if (rst || !mem_req || mem_rvalid) waitCnt <= 2'd0;
    else                               waitCnt <= waitCnt + 2'd1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChk++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // runs until stall drops, logging accepted beat addresses and request stability
  task automatic waitFill(output int n);
    logic [31:0] lastAddr;
    logic        pending;
    n = 0; nBeats = 0; holdErr = 0; pending = 1'b0; lastAddr = '0;
    while (stall_cache && n < 200) begin
      if (pending && mem_req && mem_addr !== lastAddr) holdErr++;
      pending  = mem_req && !mem_rvalid;
      lastAddr = mem_addr;
      if (mem_req && mem_rvalid) begin
        if (nBeats < 4) beatAddr[nBeats] = mem_addr;
        nBeats++;
      end
      n++;
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; fetch_en = 1'b0; inv_all = 1'b0; pcF = '0; slowMode = 1'b0;
    tick(); tick();
    chk("rstHit", hitF, 0);
    chk("rstReq", mem_req, 0);
    chk("rstAddr", mem_addr, 0);
    chk("rstHitCnt", hit_cnt, 0);
    chk("rstMissCnt", miss_cnt, 0);
    chk("rstStall", stall_cache, 0);
    rst = 1'b0;

    // cold miss, zero-wait memory
    pcF = 32'h40; fetch_en = 1'b1; #1;
    waitFill(cyc);
    chk("coldStall", cyc, 6);
    chk("coldBeats", nBeats, 4);
    for (int i = 0; i < 4; i++) chk("coldAddr", beatAddr[i], 32'h40 + 32'(4 * i));
    chk("coldHit", hitF, 1);
    chk("coldInstr", instrF, 32'hC0DE_0040);
    chk("coldMissCnt", miss_cnt, 1);
    chk("coldHitCntPre", hit_cnt, 0);
    tick();
    chk("coldHitCnt", hit_cnt, 1);

    // sequential hits in the same line
    for (int w = 1; w < 4; w++) begin
      pcF = 32'h40 + 32'(4 * w); #1;
      chk("seqHit", hitF, 1);
      chk("seqNoReq", mem_req, 0);
      chk("seqInstr", instrF, 32'hC0DE_0040 + 32'(4 * w));
      tick();
    end
    chk("seqHitCnt", hit_cnt, 4);

    // conflict on index 4
    pcF = 32'h140; #1;
    chk("confMiss", hitF, 0);
    waitFill(cyc);
    chk("confStall", cyc, 6);
    chk("confInstr", instrF, 32'hC0DE_0140);
    tick();
    pcF = 32'h40; #1;
    chk("confReMiss", hitF, 0);
    waitFill(cyc);
    chk("confReHit", hitF, 1);
    chk("confMissCnt", miss_cnt, 3);
    tick();

    // slow memory: one beat every third cycle
    slowMode = 1'b1;
    pcF = 32'h300; #1;
    waitFill(cyc);
    chk("slowStall", cyc, 14);
    chk("slowHold", holdErr, 0);
    chk("slowBeats", nBeats, 4);
    chk("slowLastAddr", beatAddr[3], 32'h30C);
    slowMode = 1'b0;
    for (int w = 0; w < 4; w++) begin
      pcF = 32'h300 + 32'(4 * w); #1;
      chk("slowHit", hitF, 1);
      chk("slowInstr", instrF, 32'hC0DE_0300 + 32'(4 * w));
      tick();
    end

    // redirect at beat 1 of the 0x80 refill
    pcF = 32'h80; #1;
    tick(); tick();
    pcF = 32'h200; #1;
    chk("redirAddr", mem_addr, 32'h84);
    tick(); tick(); tick();
    chk("redirFilled", stall_cache, 1);
    chk("redirFilledReq", mem_req, 0);
    tick();
    chk("redirNewMiss", hitF, 0);
    chk("redirNewStall", stall_cache, 1);
    chk("redirMissCntPre", miss_cnt, 5);
    waitFill(cyc);
    chk("redirNewCyc", cyc, 6);
    chk("redirNewInstr", instrF, 32'hC0DE_0200);
    tick();
    pcF = 32'h80; #1;
    chk("redirOldHit", hitF, 1);
    chk("redirOldInstr", instrF, 32'hC0DE_0080);
    tick();
    chk("redirHitCnt", hit_cnt, 12);

    // inv_all while idle
    fetch_en = 1'b0; pcF = 32'h40; inv_all = 1'b1; #1;
    chk("invIdleSame", hitF, 1);
    tick();
    inv_all = 1'b0; #1;
    chk("invIdleGone", hitF, 0);
    pcF = 32'h80; #1;
    chk("invIdleGone80", hitF, 0);

    // re-validate 0x40, then inv_all mid-refill of 0x80
    fetch_en = 1'b1; pcF = 32'h40; #1;
    waitFill(cyc);
    chk("invRefill40", hitF, 1);
    tick();
    pcF = 32'h80; #1;
    tick(); tick();
    inv_all = 1'b1; #1;
    tick();
    inv_all = 1'b0; #1;
    waitFill(cyc);
    chk("invMidNew", hitF, 1);
    chk("invMidInstr", instrF, 32'hC0DE_0080);
    tick();
    fetch_en = 1'b0; pcF = 32'h40; #1;
    chk("invMidOld", hitF, 0);

    // inv_all coinciding with the last beat
    fetch_en = 1'b1; #1;
    tick(); tick(); tick(); tick();
    inv_all = 1'b1; #1;
    chk("invLastAddr", mem_addr, 32'h4C);
    tick();
    inv_all = 1'b0; #1;
    waitFill(cyc);
    chk("invLastNew", hitF, 1);
    fetch_en = 1'b0; pcF = 32'h80; #1;
    chk("invLastOther", hitF, 0);

    // reset at beat 2 abandons the line
    fetch_en = 1'b1; #1;
    tick(); tick(); tick();
    chk("rstMidAddr", mem_addr, 32'h88);
    rst = 1'b1;
    tick();
    chk("rstMidReq", mem_req, 0);
    chk("rstMidHitCnt", hit_cnt, 0);
    chk("rstMidMissCnt", miss_cnt, 0);
    rst = 1'b0; fetch_en = 1'b0; #1;
    chk("rstMidLine", hitF, 0);
    chk("rstMidStall", stall_cache, 0);
    fetch_en = 1'b1; #1;
    chk("rstMidReMiss", stall_cache, 1);
    tick();

    $display("%0d/%0d checks passed", nPass, nChk);
    $finish;
  end

endmodule
